// File: rtl/crc_nrzi_frame_ctrl.sv
// Frame sequencer for the serial CRC + NRZI transmit path: collects a serial payload through the
// CRC engine, waits for the CRC, streams {payload, crc} MSB-first and then holds an idle gap.
module crc_nrzi_frame_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CRC_W      = 16,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CRC_TMO    = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             data_i,
  input  logic             crc_done_i,
  input  logic [CRC_W-1:0] crc_i,
  output logic             crc_clr_o,
  output logic             crc_en_o,
  output logic             crc_bit_o,
  output logic             nrzi_bit_o,
  output logic             nrzi_valid_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             crc_err_o
);

  localparam int unsigned FrameW  = DATA_W + CRC_W;
  localparam int unsigned MaxA    = (FrameW > CRC_TMO) ? FrameW : CRC_TMO;
  localparam int unsigned CntMax  = (MaxA > GAP_CYCLES) ? MaxA : GAP_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned GapLastI = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

  localparam logic [CntW-1:0] CollectLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] TmoLast     = CntW'(CRC_TMO - 1);
  localparam logic [CntW-1:0] FrameLast   = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GapLastI);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWaitCrc,
    StShift,
    StGap
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [CntW-1:0]    r_cnt;
  logic [DATA_W-1:0]  r_payload;
  logic [FrameW-1:0]  r_shift;
  logic               r_crc_en;
  logic               r_crc_bit;
  logic               r_crc_err;
  logic               w_tmo;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_tmo     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) w_state_d = StCollect;
      end
      StCollect: begin
        if (r_cnt == CollectLast) w_state_d = StWaitCrc;
      end
      StWaitCrc: begin
        if (crc_done_i) begin
          w_state_d = StShift;
        end else if (r_cnt == TmoLast) begin
          w_state_d = StIdle;
          w_tmo     = 1'b1;
        end
      end
      StShift: begin
        if (r_cnt == FrameLast) w_state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
      end
      StGap: begin
        if (r_cnt == GapLast) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // One shared counter restarts at every state change, so each state counts from zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt     <= '0;
      r_payload <= '0;
      r_shift   <= '0;
      r_crc_en  <= 1'b0;
      r_crc_bit <= 1'b0;
      r_crc_err <= 1'b0;
    end else begin
      if ((r_state == StIdle) || (w_state_d != r_state)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
      r_crc_en  <= (r_state == StCollect);
      r_crc_bit <= (r_state == StCollect) ? data_i : 1'b0;
      r_crc_err <= w_tmo;
      if (r_state == StCollect) begin
        r_payload <= {r_payload[DATA_W-2:0], data_i};
      end
      if ((r_state == StWaitCrc) && crc_done_i) begin
        r_shift <= {r_payload, crc_i};
      end else if (r_state == StShift) begin
        r_shift <= {r_shift[FrameW-2:0], 1'b0};
      end
    end
  end

  assign crc_clr_o    = (r_state == StIdle) && start_i && !reset_i;
  assign crc_en_o     = r_crc_en;
  assign crc_bit_o    = r_crc_bit;
  assign nrzi_valid_o = (r_state == StShift);
  assign nrzi_bit_o   = nrzi_valid_o && r_shift[FrameW-1];
  assign busy_o       = (r_state != StIdle);
  assign frame_done_o = nrzi_valid_o && (r_cnt == FrameLast);
  assign crc_err_o    = r_crc_err;

endmodule
